mem_request_ctrl: RTL

- Processor-side initiator for the asynchronous Enable/MFC handshake used by the 256-byte big-endian RAM.
- Turns a single-cycle CPU request into one or two handshaked RAM accesses. A doubleword becomes two word beats.
- Synchronizes MFC into the clock domain and returns read data, a completion pulse and an error flag to the datapath/control unit.

---
 rtl/mem_request_ctrl_if.sv | 36 +++
 rtl/mem_request_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_ctrl_if.sv
// Purpose: CPU-request and RAM Enable/MFC signal bundle for mem_request_ctrl.
// Latency: none, wiring only.
// Backpressure: none carried here; the controller ignores Req while Busy.
// Ports: slave = controller view (takes the CPU request, drives the RAM side),
//        master = requester/RAM view (drives the request, returns RAM data and MFC).
interface mem_request_ctrl_if;
    logic        Req;
    logic        RW;
    logic [7:0]  Addr;
    logic [1:0]  Size;
    logic        SignExt;
    logic [63:0] WrData;
    logic [63:0] RdData;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic        MemEnable;
    logic        MemReadWrite;
    logic [7:0]  MemAddress;
    logic [1:0]  MemDataSize;
    logic [31:0] MemDataOut;
    logic [31:0] MemDataIn;
    logic        MemMFC;

    modport slave (
        input  Req, RW, Addr, Size, SignExt, WrData, MemDataIn, MemMFC,
        output RdData, Busy, Done, Err,
        output MemEnable, MemReadWrite, MemAddress, MemDataSize, MemDataOut
    );

    modport master (
        output Req, RW, Addr, Size, SignExt, WrData, MemDataIn, MemMFC,
        input  RdData, Busy, Done, Err,
        input  MemEnable, MemReadWrite, MemAddress, MemDataSize, MemDataOut
    );
endinterface

// File: rtl/mem_request_ctrl.sv
// Purpose: turns a one-cycle CPU request into one or two Enable/MFC handshaked RAM word/half/byte beats.
// Latency: >= 1 + 2*(SYNC_STAGES+1) + 2 cycles per single-beat request plus RAM response time; dword repeats the beat.
// Backpressure: Req is only sampled in IDLE; requests arriving while Busy or in the Done cycle are dropped.
// Ports: Clk, Reset_n (synchronous, active low); bus (slave modport) carries the CPU request/response
//        and the RAM Enable/ReadWrite/Address/DataSize/DataOut/DataIn/MFC signals.
module mem_request_ctrl #(
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    mem_request_ctrl_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WAIT, S_CAPTURE, S_RELEASE, S_DONE, S_ERROR
    } state_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [1:0]  size;
        logic [31:0] dout;
    } beat_t;

    state_t      state_q, state_d;
    logic        rw_q, rw_d, sx_q, sx_d, beat_q, beat_d;
    logic [7:0]  addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [63:0] wdat_q, wdat_d, rdat_q, rdat_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        en_q, en_d, mrw_q, mrw_d;
    logic [7:0]  maddr_q, maddr_d;
    logic [1:0]  msize_q, msize_d;
    logic [31:0] mdout_q, mdout_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic        mfc_s;
    beat_t       bf;

    assign mfc_s = sync_q[SYNC_STAGES-1];

    // RAM-side fields of one beat; a dword is two big-endian word beats,
    // the more significant half going to the lower address.
    function automatic beat_t beat_fields(logic [7:0] a, logic [1:0] sz, logic [63:0] wd, logic b);
        beat_t r;
        case (sz)
            2'b00:   r = '{addr: a, size: 2'b00, dout: {24'b0, wd[7:0]}};
            2'b01:   r = '{addr: a, size: 2'b01, dout: {16'b0, wd[15:0]}};
            2'b10:   r = '{addr: a, size: 2'b10, dout: wd[31:0]};
            default: r = '{addr: b ? a + 8'd4 : a, size: 2'b10, dout: b ? wd[31:0] : wd[63:32]};
        endcase
        return r;
    endfunction

    function automatic logic [63:0] fmt_read(logic [1:0] sz, logic sx, logic [31:0] din);
        logic [63:0] r;
        case (sz)
            2'b00:   r = sx ? {{56{din[7]}}, din[7:0]}   : {56'b0, din[7:0]};
            2'b01:   r = sx ? {{48{din[15]}}, din[15:0]} : {48'b0, din[15:0]};
            default: r = {32'b0, din};
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        sx_d    = sx_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        en_d    = en_q;
        mrw_d   = mrw_q;
        maddr_d = maddr_q;
        msize_d = msize_q;
        mdout_d = mdout_q;
        bf      = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.Req) begin
                    rw_d    = bus.RW;
                    sx_d    = bus.SignExt;
                    addr_d  = bus.Addr;
                    size_d  = bus.Size;
                    wdat_d  = bus.WrData;
                    rdat_d  = '0;
                    beat_d  = 1'b0;
                    // Mem fields come straight from the request so they are
                    // already valid during the SETUP cycle.
                    bf      = beat_fields(bus.Addr, bus.Size, bus.WrData, 1'b0);
                    mrw_d   = bus.RW;
                    maddr_d = bf.addr;
                    msize_d = bf.size;
                    mdout_d = bf.dout;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                en_d    = 1'b1;
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mfc_s) begin
                    state_d = S_CAPTURE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                if (rw_q) begin
                    if (size_q == 2'b11) begin
                        if (beat_q) rdat_d[31:0]  = bus.MemDataIn;
                        else        rdat_d[63:32] = bus.MemDataIn;
                    end else begin
                        rdat_d = fmt_read(size_q, sx_q, bus.MemDataIn);
                    end
                end
                en_d    = 1'b0;
                tmo_d   = '0;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!mfc_s) begin
                    if (size_q == 2'b11 && !beat_q) begin
                        beat_d  = 1'b1;
                        bf      = beat_fields(addr_q, size_q, wdat_q, 1'b1);
                        maddr_d = bf.addr;
                        msize_d = bf.size;
                        mdout_d = bf.dout;
                        state_d = S_SETUP;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            rw_q    <= 1'b0;
            sx_q    <= 1'b0;
            beat_q  <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            mrw_q   <= 1'b0;
            maddr_q <= '0;
            msize_q <= '0;
            mdout_q <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            sx_q    <= sx_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            en_q    <= en_d;
            mrw_q   <= mrw_d;
            maddr_q <= maddr_d;
            msize_q <= msize_d;
            mdout_q <= mdout_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.MemMFC};
        end
    end

    assign bus.RdData       = rdat_q;
    assign bus.Busy         = busy_q;
    assign bus.Done         = done_q;
    assign bus.Err          = err_q;
    assign bus.MemEnable    = en_q;
    assign bus.MemReadWrite = mrw_q;
    assign bus.MemAddress   = maddr_q;
    assign bus.MemDataSize  = msize_q;
    assign bus.MemDataOut   = mdout_q;
endmodule
